// File: rtl/rv_pkg.sv
// Shared RV32I definitions: opcodes, instruction formats, encoder error codes
// and encoder FSM states. imm_gen is meant to use the same constants.
package rv_pkg;

  localparam logic [6:0] ALI_OP    = 7'b0010011;
  localparam logic [6:0] MEM_RD_OP = 7'b0000011;
  localparam logic [6:0] MEM_WR_OP = 7'b0100011;
  localparam logic [6:0] BR_OP     = 7'b1100011;
  localparam logic [6:0] JALR      = 7'b1100111;
  localparam logic [6:0] JAL       = 7'b1101111;
  localparam logic [6:0] LUI       = 7'b0110111;
  localparam logic [6:0] AUIPC     = 7'b0010111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_ISH = 3'd2,
    FMT_S   = 3'd3,
    FMT_B   = 3'd4,
    FMT_U   = 3'd5,
    FMT_J   = 3'd6,
    FMT_RSV = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_FMT   = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: scatters the immediate into the
// format-specific bit positions and flags out-of-range or misaligned values.
module instr_pack
  import rv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  fmt_e                    fmt,
  input  logic [6:0]              opcode,
  input  logic [4:0]              rd,
  input  logic [4:0]              rs1,
  input  logic [4:0]              rs2,
  input  logic [2:0]              funct3,
  input  logic [6:0]              funct7,
  input  logic signed [WIDTH-1:0] imm,
  output logic [WIDTH-1:0]        word,
  output logic                    legal,
  output err_code_e               code
);

  function automatic logic in_range(input logic signed [WIDTH-1:0] v,
                                    input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Pack fields per format; range is judged before alignment
  always_comb begin
    word = '0;
    code = ERR_NONE;
    unique case (fmt)
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        word = {imm[11:0], rs1, funct3, rd, opcode};
        if (!in_range(imm, -2048, 2047)) code = ERR_RANGE;
      end
      FMT_ISH: begin
        word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
        if (!in_range(imm, 0, 31)) code = ERR_RANGE;
      end
      FMT_S: begin
        word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!in_range(imm, -2048, 2047)) code = ERR_RANGE;
      end
      FMT_B: begin
        word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        if (!in_range(imm, -4096, 4094)) code = ERR_RANGE;
        else if (imm[0])                 code = ERR_ALIGN;
      end
      FMT_U: begin
        word = {imm[31:12], rd, opcode};
        if (imm[11:0] != 12'd0) code = ERR_ALIGN;
      end
      FMT_J: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (!in_range(imm, -1048576, 1048574)) code = ERR_RANGE;
        else if (imm[0])                       code = ERR_ALIGN;
      end
      default: code = ERR_FMT;
    endcase
    legal = (code == ERR_NONE);
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams packed RV32I words with their instruction-memory byte address over
// valid/ready. Any illegal field set latches a sticky error that stalls the
// stream until clear.
module instr_encoder
  import rv_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter int               DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [WIDTH-1:0]      imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_instr,
  output logic [WIDTH-1:0]      out_addr,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam logic [DEPTH_LOG2:0] MAX_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] COUNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]    ADDR_STEP = WIDTH'(4);

  state_e           state;
  logic [WIDTH-1:0] word_p0;
  logic             legal_p0;
  err_code_e        code_p0;

  // Stage p0: combinational pack of the presented fields
  instr_pack #(.WIDTH(WIDTH)) u_pack (
    .fmt    (fmt_e'(fmt)),
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .funct7 (funct7),
    .imm    ($signed(imm)),
    .word   (word_p0),
    .legal  (legal_p0),
    .code   (code_p0)
  );

  assign full = (count == MAX_COUNT);

  // Stage p1: handshake FSM with registered word, address, count and error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= BASE_ADDR;
      count     <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else if (clear) begin
      // Restart wins over a same-cycle output transfer; the held word is dropped
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_addr  <= BASE_ADDR;
      count     <= '0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (legal_p0) begin
              out_instr <= word_p0;
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end else begin
              err      <= 1'b1;
              err_code <= code_p0;
              state    <= ST_ERR;
            end
          end else begin
            in_ready <= !full;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_addr  <= out_addr + ADDR_STEP;
            count     <= count + COUNT_ONE;
            in_ready  <= ((count + COUNT_ONE) != MAX_COUNT);
            state     <= ST_IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
